sobel_grad: RTL and testbench

- Gradient stage of the edge-detection pipeline.
- Sits directly upstream of non-maximum suppression and feeds it one gradient magnitude plus one quantized 2-bit direction per pixel.
- Consumes a stream of 3-pixel columns (rows r-1, r, r+1) from the line-buffer controller and applies a 3x3 Sobel operator.
- Magnitude and angle leave together in the same cycle, on a readable strobe.

---
 rtl/sobel_grad.sv | 136 +++++++++++++
 tb/tb_sobel_grad.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_grad.sv
// Sobel gradient stage: shifts in 3-pixel columns, forms a 3x3 window and emits
// a saturated |gx|+|gy| magnitude plus a 2-bit quantized direction per window.
module sobel_grad #(
    parameter int BIT_LENGTH = 5,
    parameter int MAG_SHIFT  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [BIT_LENGTH-1:0] pixel_in0,
    input  logic [BIT_LENGTH-1:0] pixel_in1,
    input  logic [BIT_LENGTH-1:0] pixel_in2,
    output logic [BIT_LENGTH-1:0] mag_out,
    output logic [1:0]            angle_out,
    output logic                  readable
);
    localparam int GW = BIT_LENGTH + 3;
    localparam int SW = BIT_LENGTH + 4;
    localparam int AW = BIT_LENGTH + 7;
    localparam logic [SW-1:0] MAG_MAX = SW'((1 << BIT_LENGTH) - 1);

    // state   | meaning
    // LOAD    | idle, waiting for the first column
    // OPERATE | one column accepted per enabled cycle
    // FLUSH   | two cycles with no input while S1/S2 drain
    // OVER    | stream finished, outputs zero until reset
    typedef enum logic [1:0] {LOAD, OPERATE, FLUSH, OVER} state_t;

    state_t                     state;
    logic [1:0]                 col_cnt;
    logic                       flush_cnt;
    logic [2:0][BIT_LENGTH-1:0] col0, col1, col2;
    logic signed [GW-1:0]       gx_w, gy_w, gx_q, gy_q;
    logic                       v1;
    logic [GW-1:0]              ax, ay;
    logic [SW-1:0]              sum;
    logic [AW-1:0]              ax_w, ay_w;
    logic [BIT_LENGTH-1:0]      mag;
    logic [1:0]                 angle;
    logic                       accept;

    function automatic logic signed [GW-1:0] ext(input logic [BIT_LENGTH-1:0] p);
        return $signed({3'b000, p});
    endfunction

    assign accept = enable && (state == LOAD || state == OPERATE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= LOAD;
            col_cnt   <= 2'd0;
            flush_cnt <= 1'b0;
            col0      <= '0;
            col1      <= '0;
            col2      <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (enable) state <= OPERATE;
                end
                OPERATE: begin
                    if (!enable) begin
                        state     <= FLUSH;
                        flush_cnt <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == 1'b0) state <= OVER;
                    else                   flush_cnt <= flush_cnt - 1'b1;
                end
                OVER: begin
                    col0    <= '0;
                    col1    <= '0;
                    col2    <= '0;
                    col_cnt <= 2'd0;
                end
                default: state <= OVER;
            endcase
            if (accept) begin
                col0 <= col1;
                col1 <= col2;
                col2 <= {pixel_in2, pixel_in1, pixel_in0};
                if (col_cnt != 2'd3) col_cnt <= col_cnt + 2'd1;
            end
        end
    end

    always_comb begin
        gx_w = (ext(col2[0]) + (ext(col2[1]) <<< 1) + ext(col2[2]))
             - (ext(col0[0]) + (ext(col0[1]) <<< 1) + ext(col0[2]));
        gy_w = (ext(col0[2]) + (ext(col1[2]) <<< 1) + ext(col2[2]))
             - (ext(col0[0]) + (ext(col1[0]) <<< 1) + ext(col2[0]));
    end

    // S1: only windows seen while streaming are valid; FLUSH/OVER drain only
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gx_q <= '0;
            gy_q <= '0;
            v1   <= 1'b0;
        end else begin
            gx_q <= gx_w;
            gy_q <= gy_w;
            v1   <= (state == OPERATE) && (col_cnt == 2'd3);
        end
    end

    always_comb begin
        ax    = gx_q[GW-1] ? -gx_q : gx_q;
        ay    = gy_q[GW-1] ? -gy_q : gy_q;
        sum   = ({1'b0, ax} + {1'b0, ay}) >> MAG_SHIFT;
        mag   = (sum > MAG_MAX) ? MAG_MAX[BIT_LENGTH-1:0] : sum[BIT_LENGTH-1:0];
        ax_w  = {{(AW-GW){1'b0}}, ax};
        ay_w  = {{(AW-GW){1'b0}}, ay};
        // tan(22.5) ~ 2/5 and tan(67.5) ~ 5/2 split the four direction bins
        angle = 2'b01;
        if (((ay_w << 2) + ay_w) <= (ax_w << 1))
            angle = 2'b00;
        else if ((ay_w << 1) >= ((ax_w << 2) + ax_w))
            angle = 2'b10;
        else if (gx_q[GW-1] == gy_q[GW-1])
            angle = 2'b11;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mag_out   <= '0;
            angle_out <= 2'b00;
            readable  <= 1'b0;
        end else begin
            mag_out   <= v1 ? mag : '0;
            angle_out <= v1 ? angle : 2'b00;
            readable  <= v1;
        end
    end
endmodule

// File: tb/tb_sobel_grad.sv
// Bench for sobel_grad: window-level reference model checked every cycle, plus
// literal expectations per directed stream. Second instance runs MAG_SHIFT=0.
module tb_sobel_grad;
    localparam int BL = 5;

    logic          clk = 1'b0, reset = 1'b1, enable = 1'b0;
    logic [BL-1:0] p0 = '0, p1 = '0, p2 = '0;
    logic [BL-1:0] mag_a, mag_b;
    logic [1:0]    ang_a, ang_b;
    logic          rd_a, rd_b;

    sobel_grad #(.BIT_LENGTH(BL), .MAG_SHIFT(2)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .pixel_in0(p0), .pixel_in1(p1), .pixel_in2(p2),
        .mag_out(mag_a), .angle_out(ang_a), .readable(rd_a));

    sobel_grad #(.BIT_LENGTH(BL), .MAG_SHIFT(0)) dut_sat (
        .clk(clk), .reset(reset), .enable(enable),
        .pixel_in0(p0), .pixel_in1(p1), .pixel_in2(p2),
        .mag_out(mag_b), .angle_out(ang_b), .readable(rd_b));

    always #5 clk = ~clk;

    typedef struct {int due; int mag; int mag_sat; int ang;} exp_t;
    typedef struct {int cyc; int mag; int mag_sat; int ang;} cap_t;

    int   total = 0, bad = 0, cyc = 0;
    int   last_edge = 0;
    exp_t expq[$];
    cap_t capq[$];
    int   win[3][3];
    int   nwin = 0;
    int   phase = 0;   // 0 idle, 1 streaming, 2 stream ended
    bit   want;
    cap_t cap;

    task automatic chk(input string name, input int got, input int exp_v);
        total++;
        if (got != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp_v, cyc);
        end
    endtask

    function automatic int min31(input int v);
        return (v > 31) ? 31 : v;
    endfunction

    function automatic exp_t predict(input int due);
        exp_t e;
        int gx, gy, ax, ay;
        gx = (win[2][0] + 2*win[2][1] + win[2][2]) - (win[0][0] + 2*win[0][1] + win[0][2]);
        gy = (win[0][2] + 2*win[1][2] + win[2][2]) - (win[0][0] + 2*win[1][0] + win[2][0]);
        ax = (gx < 0) ? -gx : gx;
        ay = (gy < 0) ? -gy : gy;
        e.due     = due;
        e.mag     = min31((ax + ay) >> 2);
        e.mag_sat = min31(ax + ay);
        if (5*ay <= 2*ax)                 e.ang = 0;
        else if (2*ay >= 5*ax)            e.ang = 2;
        else if ((gx >= 0) == (gy >= 0))  e.ang = 3;
        else                              e.ang = 1;
        return e;
    endfunction

    // reference model: tracks accepted columns and schedules outputs 2 edges later
    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            phase = 0;
            nwin  = 0;
            expq.delete();
        end else if (phase < 2) begin
            if (enable) begin
                win[0] = win[1];
                win[1] = win[2];
                win[2] = '{int'(p0), int'(p1), int'(p2)};
                if (nwin < 3) nwin++;
                if (nwin == 3) expq.push_back(predict(cyc + 2));
                phase = 1;
            end else if (phase == 1) begin
                phase = 2;
            end
        end
    end

    always @(negedge clk) begin
        while (expq.size() > 0 && expq[0].due < cyc) expq.delete(0);
        want = (expq.size() > 0) && (expq[0].due == cyc);
        chk("readable", int'(rd_a), int'(want));
        chk("readable_sat", int'(rd_b), int'(want));
        if (want) begin
            chk("mag", int'(mag_a), expq[0].mag);
            chk("angle", int'(ang_a), expq[0].ang);
            chk("mag_sat", int'(mag_b), expq[0].mag_sat);
            expq.delete(0);
        end
        if (rd_a) begin
            cap.cyc = cyc; cap.mag = int'(mag_a); cap.mag_sat = int'(mag_b); cap.ang = int'(ang_a);
            capq.push_back(cap);
        end
    end

    task automatic send_col(input int a, input int b, input int c);
        @(negedge clk); #1;
        enable = 1'b1;
        p0 = BL'(a); p1 = BL'(b); p2 = BL'(c);
        last_edge = cyc + 1;
    endtask

    task automatic end_stream();
        @(negedge clk); #1;
        enable = 1'b0;
        repeat (8) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        reset = 1'b1; enable = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b0;
        capq.delete();
    endtask

    task automatic check_caps(input string name, input int n, input int m, input int ms, input int ang);
        chk({name, "_count"}, capq.size(), n);
        foreach (capq[i]) begin
            chk({name, "_mag"}, capq[i].mag, m);
            chk({name, "_mag_sat"}, capq[i].mag_sat, ms);
            chk({name, "_angle"}, capq[i].ang, ang);
        end
    endtask

    int first;
    initial begin
        @(negedge clk); #1;
        chk("reset_readable", int'(rd_a), 0);
        chk("reset_mag", int'(mag_a), 0);
        chk("reset_angle", int'(ang_a), 0);
        reset = 1'b0;

        // flat field
        do_reset();
        for (int i = 0; i < 6; i++) begin
            send_col(10, 10, 10);
            if (i == 0) first = last_edge;
        end
        end_stream();
        check_caps("flat", 4, 0, 0, 0);
        if (capq.size() == 4) begin
            chk("flat_first_cycle", capq[0].cyc, first + 4);
            chk("flat_last_cycle", capq[3].cyc, first + 7);
        end

        // vertical edge (saturating in the MAG_SHIFT=0 instance)
        do_reset();
        send_col(0, 0, 0); send_col(0, 0, 0); send_col(31, 31, 31); send_col(31, 31, 31);
        end_stream();
        check_caps("vert", 2, 31, 31, 0);

        // horizontal edge
        do_reset();
        for (int i = 0; i < 4; i++) send_col(0, 0, 31);
        end_stream();
        check_caps("horiz", 2, 31, 31, 2);

        // diagonals
        do_reset();
        send_col(0, 0, 0); send_col(0, 0, 8); send_col(0, 8, 8);
        end_stream();
        check_caps("diag_pos", 1, 12, 31, 3);

        do_reset();
        send_col(0, 0, 0); send_col(8, 0, 0); send_col(8, 8, 0);
        end_stream();
        check_caps("diag_neg", 1, 12, 31, 1);

        // irregular content, model only
        do_reset();
        send_col(3, 7, 1); send_col(20, 5, 9); send_col(12, 30, 2);
        send_col(0, 17, 25); send_col(31, 4, 6); send_col(9, 9, 28);
        end_stream();
        chk("mixed_count", capq.size(), 4);

        // termination, then ignored enables
        do_reset();
        send_col(0, 0, 0); send_col(0, 0, 0);
        send_col(31, 31, 31); send_col(31, 31, 31); send_col(31, 31, 31);
        end_stream();
        chk("term_count", capq.size(), 3);
        if (capq.size() == 3) begin
            chk("term_mag0", capq[0].mag, 31);
            chk("term_mag1", capq[1].mag, 31);
            chk("term_mag2", capq[2].mag, 0);
        end
        chk("over_readable", int'(rd_a), 0);
        chk("over_mag", int'(mag_a), 0);
        chk("over_angle", int'(ang_a), 0);
        for (int i = 0; i < 3; i++) send_col(31, 0, 31);
        end_stream();
        chk("over_pulse_count", capq.size(), 3);

        // reset between outputs, then a fresh stream
        do_reset();
        send_col(0, 0, 0); send_col(0, 0, 0);
        send_col(31, 31, 31); send_col(31, 31, 31); send_col(31, 31, 31);
        @(negedge clk); #1;
        chk("pre_reset_readable", int'(rd_a), 1);
        chk("pre_reset_mag", int'(mag_a), 31);
        reset = 1'b1; enable = 1'b0;
        #1;
        chk("async_reset_readable", int'(rd_a), 0);
        chk("async_reset_mag", int'(mag_a), 0);
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b0;
        capq.delete();
        send_col(0, 0, 0); send_col(0, 0, 0); send_col(31, 31, 31);
        first = last_edge;
        end_stream();
        chk("restart_count", capq.size(), 1);
        if (capq.size() == 1) begin
            chk("restart_cycle", capq[0].cyc, first + 2);
            chk("restart_mag", capq[0].mag, 31);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
